execute_pipe: RTL and testbench

// Parametrised, registered execute stage for the LEGv8 pipeline; successor to the

---
 rtl/execute_pipe.sv | 126 ++++++++++++
 tb/tb_execute_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/execute_pipe.sv
// Registered LEGv8 execute stage: single-cycle ALU path and an iterative shift-add
// multiplier, both feeding an EX/MEM output register with a valid/stall handshake.
module execute_pipe #(
   parameter int unsigned N        = 64,
   parameter int unsigned MUL_STEP = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_E,
   output logic         ready_E,
   input  logic         AluSrc_E,
   input  logic [3:0]   AluControl_E,
   input  logic         mul_E,
   input  logic [N-1:0] PC_E,
   input  logic [N-1:0] signImm_E,
   input  logic [N-1:0] readData1_E,
   input  logic [N-1:0] readData2_E,
   input  logic         stall_M,
   output logic         valid_M,
   output logic [N-1:0] aluResult_M,
   output logic         zero_M,
   output logic [N-1:0] PCBranch_M,
   output logic [N-1:0] writeData_M
);

   localparam int unsigned ITERS = N / MUL_STEP;
   localparam int unsigned CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
   localparam logic [N-1:0] DIGIT_MASK = ~({N{1'b1}} << MUL_STEP);

   typedef enum logic [0:0] {StIdle, StMul} state_t;

   state_t        state;
   logic [N-1:0]  a_q, b_q, pcb_q, wd_q, acc_q;
   logic [CW-1:0] cnt;

   logic [N-1:0]  opb, alu_res, pcb_next;
   logic [N-1:0]  a_shift, digit, partial, acc_next;
   logic [31:0]   sh;
   logic          accept, out_free, last;

   assign ready_E  = (state == StIdle) && !(valid_M && stall_M) && !reset;
   assign accept   = valid_E && ready_E;
   assign out_free = !valid_M || !stall_M;
   assign last     = (cnt == LAST);
   assign opb      = AluSrc_E ? signImm_E : readData2_E;
   assign pcb_next = PC_E + (signImm_E << 2);

   always_comb begin
      alu_res = '0;
      case (AluControl_E)
         4'b0000: alu_res = readData1_E & opb;
         4'b0001: alu_res = readData1_E | opb;
         4'b0010: alu_res = readData1_E + opb;
         4'b0110: alu_res = readData1_E - opb;
         4'b0111: alu_res = opb;
         4'b1100: alu_res = ~(readData1_E | opb);
         default: alu_res = '0;
      endcase
   end

   // One radix-2^MUL_STEP digit of B per cycle, LSB digit first.
   always_comb begin
      sh       = 32'(cnt) * MUL_STEP;
      a_shift  = a_q << sh;
      digit    = (b_q >> sh) & DIGIT_MASK;
      partial  = a_shift * digit;
      acc_next = acc_q + partial;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StIdle;
         cnt         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         pcb_q       <= '0;
         wd_q        <= '0;
         acc_q       <= '0;
         valid_M     <= 1'b0;
         aluResult_M <= '0;
         zero_M      <= 1'b1;
         PCBranch_M  <= '0;
         writeData_M <= '0;
      end else begin
         // Memory stage takes the result; a load below overrides this.
         if (valid_M && !stall_M) valid_M <= 1'b0;
         case (state)
            StIdle: begin
               if (accept) begin
                  if (mul_E) begin
                     a_q   <= readData1_E;
                     b_q   <= opb;
                     pcb_q <= pcb_next;
                     wd_q  <= readData2_E;
                     acc_q <= '0;
                     cnt   <= '0;
                     state <= StMul;
                  end else begin
                     valid_M     <= 1'b1;
                     aluResult_M <= alu_res;
                     zero_M      <= (alu_res == '0);
                     PCBranch_M  <= pcb_next;
                     writeData_M <= readData2_E;
                  end
               end
            end
            StMul: begin
               if (!last) begin
                  acc_q <= acc_next;
                  cnt   <= cnt + 1'b1;
               end else if (out_free) begin
                  valid_M     <= 1'b1;
                  aluResult_M <= acc_next;
                  zero_M      <= (acc_next == '0);
                  PCBranch_M  <= pcb_q;
                  writeData_M <= wd_q;
                  state       <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_execute_pipe.sv
// Directed plus randomized bench for execute_pipe (N=64, MUL_STEP=1) against a
// plain-arithmetic reference model.
module tb_execute_pipe;

   localparam int N = 64;

   logic         clk = 1'b0;
   logic         reset, valid_E, ready_E, AluSrc_E, mul_E, stall_M;
   logic [3:0]   AluControl_E;
   logic [N-1:0] PC_E, signImm_E, readData1_E, readData2_E;
   logic         valid_M, zero_M;
   logic [N-1:0] aluResult_M, PCBranch_M, writeData_M;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   execute_pipe #(.N(N), .MUL_STEP(1)) dut (
      .clk(clk), .reset(reset), .valid_E(valid_E), .ready_E(ready_E),
      .AluSrc_E(AluSrc_E), .AluControl_E(AluControl_E), .mul_E(mul_E),
      .PC_E(PC_E), .signImm_E(signImm_E), .readData1_E(readData1_E),
      .readData2_E(readData2_E), .stall_M(stall_M), .valid_M(valid_M),
      .aluResult_M(aluResult_M), .zero_M(zero_M), .PCBranch_M(PCBranch_M),
      .writeData_M(writeData_M)
   );

   function automatic logic [N-1:0] ref_alu(input logic [3:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         4'd7:    return b;
         4'd12:   return ~(a | b);
         default: return '0;
      endcase
   endfunction

   function automatic logic [N-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inputs(input logic mul, input logic [3:0] op, input logic src,
                             input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [N-1:0] imm, input logic [N-1:0] pc);
      valid_E = 1'b1; mul_E = mul; AluControl_E = op; AluSrc_E = src;
      readData1_E = a; readData2_E = b; signImm_E = imm; PC_E = pc;
   endtask

   task automatic scramble();
      AluControl_E = 4'($urandom); AluSrc_E = 1'($urandom);
      readData1_E = rnd64(); readData2_E = rnd64(); signImm_E = rnd64(); PC_E = rnd64();
   endtask

   task automatic alu_op(input string tag, input logic [3:0] op, input logic src,
                         input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] imm, input logic [N-1:0] pc);
      logic [N-1:0] exp;
      exp = ref_alu(op, a, src ? imm : b);
      set_inputs(1'b0, op, src, a, b, imm, pc);
      check({tag, ".ready"}, N'(ready_E), N'(1));
      step();
      valid_E = 1'b0;
      scramble();
      check({tag, ".valid"}, N'(valid_M), N'(1));
      check({tag, ".result"}, aluResult_M, exp);
      check({tag, ".zero"}, N'(zero_M), N'(exp == '0));
      check({tag, ".pcbranch"}, PCBranch_M, pc + imm * 4);
      check({tag, ".wdata"}, writeData_M, b);
   endtask

   task automatic mul_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] imm, input logic [N-1:0] pc);
      int lat;
      int bad;
      set_inputs(1'b1, 4'($urandom), 1'b0, a, b, imm, pc);
      step();
      valid_E = 1'b0;
      scramble();
      lat = 0;
      bad = 0;
      while (!valid_M && lat < 200) begin
         if (ready_E) bad++;
         step();
         lat++;
      end
      check({tag, ".latency"}, N'(lat), N'(64));
      check({tag, ".ready_low"}, N'(bad), N'(0));
      check({tag, ".result"}, aluResult_M, a * b);
      check({tag, ".zero"}, N'(zero_M), N'((a * b) == '0));
      check({tag, ".pcbranch"}, PCBranch_M, pc + imm * 4);
      check({tag, ".wdata"}, writeData_M, b);
   endtask

   initial begin
      logic [N-1:0] ra, rb, x_res;
      logic [3:0]   op;
      int           seen;
      logic [3:0]   ops [6];
      ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

      reset = 1'b1; valid_E = 1'b0; stall_M = 1'b0; mul_E = 1'b0;
      AluControl_E = '0; AluSrc_E = 1'b0;
      PC_E = '0; signImm_E = '0; readData1_E = '0; readData2_E = '0;
      step();
      step();
      check("rst.valid", N'(valid_M), N'(0));
      check("rst.result", aluResult_M, '0);
      check("rst.zero", N'(zero_M), N'(1));
      check("rst.ready", N'(ready_E), N'(0));
      check("rst.pcbranch", PCBranch_M, '0);
      check("rst.wdata", writeData_M, '0);
      reset = 1'b0;
      #1;
      check("post_rst.ready", N'(ready_E), N'(1));

      alu_op("add", 4'b0010, 1'b0, 64'd5, 64'd7, 64'd0, 64'd0);
      check("add.literal", aluResult_M, 64'd12);
      alu_op("sub", 4'b0110, 1'b0, 64'h1234, 64'h1234, '1, 64'h100);
      check("sub.zero_lit", N'(zero_M), N'(1));
      check("sub.pcb_lit", PCBranch_M, 64'hFC);

      for (int i = 0; i < 24; i++) begin
         ra = rnd64();
         rb = ($urandom_range(0, 3) == 0) ? ra : rnd64();
         op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 5)];
         alu_op($sformatf("rnd_alu%0d", i), op, 1'($urandom), ra, rb, rnd64(), rnd64());
      end

      mul_op("mul_ff3", '1, 64'd3, 64'd4, 64'h40);
      check("mul_ff3.literal", aluResult_M, 64'hFFFF_FFFF_FFFF_FFFD);
      for (int i = 0; i < 3; i++)
         mul_op($sformatf("rnd_mul%0d", i), rnd64(), rnd64(), rnd64(), rnd64());
      mul_op("mul_zero", rnd64(), 64'd0, 64'd1, 64'd8);

      // Back-pressure: held result, blocked acceptance, then clean hand-over.
      alu_op("x", 4'b0001, 1'b0, 64'hA0, 64'h0B, 64'd1, 64'd0);
      x_res = 64'hAB;
      stall_M = 1'b1;
      set_inputs(1'b0, 4'b0010, 1'b1, 64'd100, 64'd9, 64'd23, 64'd0);
      #1;
      check("stall.ready", N'(ready_E), N'(0));
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("stall.hold%0d", i), aluResult_M, x_res);
         check($sformatf("stall.valid%0d", i), N'(valid_M), N'(1));
         check($sformatf("stall.wdata%0d", i), writeData_M, 64'h0B);
      end
      stall_M = 1'b0;
      #1;
      check("unstall.ready", N'(ready_E), N'(1));
      step();
      valid_E = 1'b0;
      check("y.result", aluResult_M, 64'd123);
      check("y.valid", N'(valid_M), N'(1));
      check("y.wdata", writeData_M, 64'd9);
      step();
      check("y.taken", N'(valid_M), N'(0));

      // Reset in the middle of a multiply must discard it.
      set_inputs(1'b1, 4'd0, 1'b0, 64'd7, 64'd6, 64'd0, 64'd0);
      step();
      valid_E = 1'b0;
      for (int i = 0; i < 10; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      check("abort.valid", N'(valid_M), N'(0));
      check("abort.ready", N'(ready_E), N'(1));
      seen = 0;
      for (int i = 0; i < 70; i++) begin
         step();
         if (valid_M) seen++;
      end
      check("abort.no_result", N'(seen), N'(0));
      alu_op("or_after", 4'b0001, 1'b0, 64'd2, 64'd1, 64'd0, 64'd0);
      check("or_after.literal", aluResult_M, 64'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
